// File: rtl/aes_inv_round_ctrl.sv
// AES inverse-cipher round sequencer: one 128-bit state register, key fetch from external RAM.
// Optional build macro AES_DEC_ABORT_EN adds an abort input that cancels the block in flight.

package aes_inv_gf_pkg;
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            else      acc = acc;
            if (x[7]) x = {x[6:0], 1'b0} ^ 8'h1b;
            else      x = {x[6:0], 1'b0};
        end
        return acc;
    endfunction
endpackage

module inv_shift_rows (
    input  logic [127:0] din_i,
    output logic [127:0] dout_o
);
    // Row r of the column-major state rotates right by r byte positions.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign dout_o[127-8*(r+4*c) -: 8] = din_i[127-8*(r+4*((c+4-r)%4)) -: 8];
        end
    end
endmodule

module inv_sub_byte (
    input  logic       startTransition,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o
);
    import aes_inv_gf_pkg::*;

    function automatic logic [7:0] inv_affine(input logic [7:0] y);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = y[(i+2)%8] ^ y[(i+5)%8] ^ y[(i+7)%8];
        end
        return b ^ 8'h05;
    endfunction

    // Multiplicative inverse as x^254; zero maps to zero naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Inverse S-box when enabled, transparent otherwise.
    always_comb begin
        if (startTransition) dout_o = gf_inv(inv_affine(din_i));
        else                 dout_o = din_i;
    end
endmodule

module add_round_key (
    input  logic [127:0] din_i,
    input  logic [127:0] key_i,
    output logic [127:0] dout_o
);
    assign dout_o = din_i ^ key_i;
endmodule

module inv_mix_columns (
    input  logic [127:0] din_i,
    output logic [127:0] dout_o
);
    import aes_inv_gf_pkg::*;

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] s0_s, s1_s, s2_s, s3_s;
        assign {s0_s, s1_s, s2_s, s3_s} = din_i[127-32*c -: 32];
        assign dout_o[127-32*c -: 32] = {
            gf_mul(s0_s, 8'h0e) ^ gf_mul(s1_s, 8'h0b) ^ gf_mul(s2_s, 8'h0d) ^ gf_mul(s3_s, 8'h09),
            gf_mul(s0_s, 8'h09) ^ gf_mul(s1_s, 8'h0e) ^ gf_mul(s2_s, 8'h0b) ^ gf_mul(s3_s, 8'h0d),
            gf_mul(s0_s, 8'h0d) ^ gf_mul(s1_s, 8'h09) ^ gf_mul(s2_s, 8'h0e) ^ gf_mul(s3_s, 8'h0b),
            gf_mul(s0_s, 8'h0b) ^ gf_mul(s1_s, 8'h0d) ^ gf_mul(s2_s, 8'h09) ^ gf_mul(s3_s, 8'h0e)};
    end
endmodule

module aes_inv_round_ctrl #(
    parameter int NUM_ROUNDS  = 10,
    parameter int KEY_LATENCY = 1
) (
    input  logic         clock50MHz,
    input  logic         resetn,
    input  logic         start,
`ifdef AES_DEC_ABORT_EN
    input  logic         abort,
`endif
    input  logic [127:0] cipherIn,
    output logic [3:0]   keyIndex,
    input  logic [127:0] roundKey,
    output logic         busy,
    output logic         done,
    output logic [127:0] plainOut
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_APPLY = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [3:0] NR4     = 4'(NUM_ROUNDS);
    localparam logic [1:0] WAIT_M1 = 2'(KEY_LATENCY - 1);

    logic [1:0]   rst_sync_q;
    logic         rst_n_s;
    logic         abort_s;
    logic [1:0]   state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [1:0]   wait_q, wait_d;
    logic [3:0]   key_idx_q, key_idx_d;
    logic [127:0] st_q, st_d;
    logic [127:0] plain_q, plain_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [127:0] isr_s, isb_s, ark_in_s, ark_s, imc_s;

`ifdef AES_DEC_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Reset asserts immediately, releases two edges after resetn rises.
    always_ff @(posedge clock50MHz or negedge resetn) begin
        if (!resetn) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_s = rst_sync_q[1];

    inv_shift_rows u_isr (.din_i(st_q), .dout_o(isr_s));
    for (genvar b = 0; b < 16; b++) begin : g_sbox
        inv_sub_byte u_isb (.startTransition(1'b1), .din_i(isr_s[8*b +: 8]), .dout_o(isb_s[8*b +: 8]));
    end

    // The initial whitening round adds the key to the raw ciphertext.
    always_comb begin
        if (round_q == NR4) ark_in_s = st_q;
        else                ark_in_s = isb_s;
    end

    add_round_key   u_ark (.din_i(ark_in_s), .key_i(roundKey), .dout_o(ark_s));
    inv_mix_columns u_imc (.din_i(ark_s), .dout_o(imc_s));

    // Sequencer next-state: abort takes priority over any state update.
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        wait_d    = wait_q;
        key_idx_d = key_idx_q;
        st_d      = st_q;
        plain_d   = plain_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    st_d      = cipherIn;
                    key_idx_d = NR4;
                    round_d   = NR4;
                    wait_d    = WAIT_M1;
                    busy_d    = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_FETCH: begin
                if (abort_s) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (wait_q == 2'd0) begin
                    state_d = S_APPLY;
                end else begin
                    wait_d  = wait_q - 2'd1;
                end
            end
            S_APPLY: begin
                if (abort_s) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (round_q == 4'd0) begin
                    st_d    = ark_s;
                    plain_d = ark_s;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    if (round_q == NR4) st_d = ark_s;
                    else                st_d = imc_s;
                    round_d   = round_q - 4'd1;
                    key_idx_d = round_q - 4'd1;
                    wait_d    = WAIT_M1;
                    state_d   = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock50MHz or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q   <= S_IDLE;
            round_q   <= 4'd0;
            wait_q    <= 2'd0;
            key_idx_q <= 4'd0;
            st_q      <= 128'd0;
            plain_q   <= 128'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            wait_q    <= wait_d;
            key_idx_q <= key_idx_d;
            st_q      <= st_d;
            plain_q   <= plain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign keyIndex = key_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign plainOut = plain_q;
endmodule
